// File: rtl/ifu_fetch_fsm.sv
// Instruction-fetch control FSM: holds the PC, issues one AR/R read per instruction
// and hands {pc, inst, err} to decode over a valid/ready handshake.
module ifu_fetch_fsm #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h8000_0000),
    parameter int                 TIMEOUT  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [ADDR_W-1:0] next_pc_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp_i,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              fetch_err_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_IDLE = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_WAIT = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               tmo_hit_s;

    // Saturating timeout counter; expiry fires on the TIMEOUT-th cycle spent in ADDR/DATA.
    always_comb begin
        cnt_inc_s = cnt_q;
        tmo_hit_s = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_W'(1'b1);
        end
        if (TIMEOUT != 0) begin
            tmo_hit_s = (cnt_q == TMO_LAST);
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_ADDR;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_IDLE: begin
                if (valid_pre_i) begin
                    pc_d  = next_pc_i;
                    err_d = 1'b0;
                    if (next_pc_i[1:0] == 2'b00) begin
                        state_d = ST_ADDR;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        // Misaligned PC never reaches the bus.
                        state_d = ST_WAIT;
                        err_d   = 1'b1;
                        inst_d  = 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                cnt_d = cnt_inc_s;
                if (tmo_hit_s) begin
                    state_d = ST_WAIT;
                    err_d   = 1'b1;
                    inst_d  = 32'h0000_0000;
                end else if (arready_i) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_inc_s;
                // Data beats the timeout when both land in the same cycle.
                if (rvalid_i) begin
                    state_d = ST_WAIT;
                    inst_d  = rdata_i;
                    err_d   = (rresp_i != 2'b00);
                end else if (tmo_hit_s) begin
                    state_d = ST_WAIT;
                    err_d   = 1'b1;
                    inst_d  = 32'h0000_0000;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (ready_post_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_pre_o  = (state_q == ST_IDLE);
    assign arvalid_o    = (state_q == ST_ADDR);
    assign rready_o     = (state_q == ST_DATA);
    assign valid_post_o = (state_q == ST_WAIT);
    assign araddr_o     = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_ifu_fetch_fsm.sv
// Directed bench for ifu_fetch_fsm: a default-timeout instance and a TIMEOUT=4 instance
// share the same stimulus; each scenario task checks the instance it targets.
module tb_ifu_fetch_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_pre_i;
    logic [31:0] next_pc_i;
    logic        arready_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        ready_post_i;

    logic        ready_pre_o,  arvalid_o,  rready_o,  valid_post_o,  fetch_err_o;
    logic [31:0] araddr_o, pc_o, inst_o;
    logic        t_ready_pre_o, t_arvalid_o, t_rready_o, t_valid_post_o, t_fetch_err_o;
    logic [31:0] t_araddr_o, t_pc_o, t_inst_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifu_fetch_fsm dut (
        .clock(clk), .reset(reset),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .next_pc_i(next_pc_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o)
    );

    ifu_fetch_fsm #(.TIMEOUT(4)) dut_t (
        .clock(clk), .reset(reset),
        .valid_pre_i(valid_pre_i), .ready_pre_o(t_ready_pre_o), .next_pc_i(next_pc_i),
        .arvalid_o(t_arvalid_o), .arready_i(arready_i), .araddr_o(t_araddr_o),
        .rvalid_i(rvalid_i), .rready_o(t_rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .valid_post_o(t_valid_post_o), .ready_post_i(ready_post_i),
        .pc_o(t_pc_o), .inst_o(t_inst_o), .fetch_err_o(t_fetch_err_o)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_pre_i = 1'b0; next_pc_i = 32'h0; arready_i = 1'b1;
        rvalid_i = 1'b1; rdata_i = 32'h0010_0093; rresp_i = 2'b00; ready_post_i = 1'b0;
        step(); step();
        checks++;
        if ({ready_pre_o, arvalid_o, rready_o, valid_post_o, fetch_err_o} !== 5'b00000) begin
            errors++; $display("FAIL reset_hs: got %b expected 00000",
                {ready_pre_o, arvalid_o, rready_o, valid_post_o, fetch_err_o});
        end
        checks++;
        if ({pc_o, inst_o} !== {32'h8000_0000, 32'h0}) begin
            errors++; $display("FAIL reset_regs: got pc=%h inst=%h expected 80000000/0", pc_o, inst_o);
        end
    endtask

    task automatic test_first_fetch();
        reset = 1'b1;
        checks++;
        if (arvalid_o !== 1'b0) begin
            errors++; $display("FAIL boot_cycle0: got arvalid=%b expected 0", arvalid_o);
        end
        step();
        checks++;
        if ({arvalid_o, araddr_o} !== {1'b1, 32'h8000_0000}) begin
            errors++; $display("FAIL c1_ar: got %b/%h expected 1/80000000", arvalid_o, araddr_o);
        end
        step();
        checks++;
        if ({rready_o, valid_post_o} !== 2'b10) begin
            errors++; $display("FAIL c2_data: got %b expected 10", {rready_o, valid_post_o});
        end
        step();
        checks++;
        if ({valid_post_o, inst_o, pc_o, fetch_err_o} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
            errors++; $display("FAIL c3_post: got v=%b inst=%h pc=%h err=%b expected 1/00100093/80000000/0",
                valid_post_o, inst_o, pc_o, fetch_err_o);
        end
    endtask

    task automatic test_backpressure();
        rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({valid_post_o, inst_o, pc_o, fetch_err_o} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
                errors++; $display("FAIL hold_%0d: got v=%b inst=%h pc=%h err=%b", i,
                    valid_post_o, inst_o, pc_o, fetch_err_o);
            end
        end
        ready_post_i = 1'b1;
        step();
        ready_post_i = 1'b0;
        checks++;
        if ({ready_pre_o, valid_post_o} !== 2'b10) begin
            errors++; $display("FAIL to_idle: got %b expected 10", {ready_pre_o, valid_post_o});
        end
    endtask

    task automatic test_ar_stall();
        valid_pre_i = 1'b1; next_pc_i = 32'h8000_0004; arready_i = 1'b0; rvalid_i = 1'b1;
        step();
        valid_pre_i = 1'b0; next_pc_i = 32'h1234_5670;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) arready_i = 1'b1;
            checks++;
            if ({arvalid_o, araddr_o} !== {1'b1, 32'h8000_0004}) begin
                errors++; $display("FAIL ar_hold_%0d: got %b/%h expected 1/80000004", i, arvalid_o, araddr_o);
            end
            step();
        end
        // rvalid was high together with arready; it must not have been taken in ADDR.
        arready_i = 1'b0; rdata_i = 32'h0000_0013;
        checks++;
        if ({rready_o, valid_post_o} !== 2'b10) begin
            errors++; $display("FAIL ar_rv_same: got %b expected 10", {rready_o, valid_post_o});
        end
        step();
        checks++;
        if ({valid_post_o, inst_o, pc_o, fetch_err_o} !== {1'b1, 32'h0000_0013, 32'h8000_0004, 1'b0}) begin
            errors++; $display("FAIL stall_post: got v=%b inst=%h pc=%h err=%b expected 1/00000013/80000004/0",
                valid_post_o, inst_o, pc_o, fetch_err_o);
        end
        ready_post_i = 1'b1; step(); ready_post_i = 1'b0;
    endtask

    task automatic test_bus_error();
        valid_pre_i = 1'b1; next_pc_i = 32'h8000_0008; arready_i = 1'b1; rvalid_i = 1'b1;
        rdata_i = 32'hDEAD_BEEF; rresp_i = 2'b10;
        step();
        valid_pre_i = 1'b0;
        step(); step();
        checks++;
        if ({valid_post_o, fetch_err_o, inst_o} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL bus_err: got v=%b err=%b inst=%h expected 1/1/deadbeef",
                valid_post_o, fetch_err_o, inst_o);
        end
        rresp_i = 2'b00;
        ready_post_i = 1'b1; step(); ready_post_i = 1'b0;
    endtask

    task automatic test_misaligned();
        valid_pre_i = 1'b1; next_pc_i = 32'h8000_0006;
        step();
        valid_pre_i = 1'b0;
        checks++;
        if ({arvalid_o, valid_post_o, fetch_err_o, pc_o, inst_o} !== {1'b0, 1'b1, 1'b1, 32'h8000_0006, 32'h0}) begin
            errors++; $display("FAIL misalign: got ar=%b v=%b err=%b pc=%h inst=%h expected 0/1/1/80000006/0",
                arvalid_o, valid_post_o, fetch_err_o, pc_o, inst_o);
        end
        ready_post_i = 1'b1; step(); ready_post_i = 1'b0;
    endtask

    task automatic test_timeout();
        reset = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if ({t_arvalid_o, t_valid_post_o} !== 2'b10) begin
                errors++; $display("FAIL tmo_addr_%0d: got %b expected 10", i, {t_arvalid_o, t_valid_post_o});
            end
        end
        step();
        checks++;
        if ({t_valid_post_o, t_fetch_err_o, t_inst_o, t_pc_o} !== {1'b1, 1'b1, 32'h0, 32'h8000_0000}) begin
            errors++; $display("FAIL tmo_err: got v=%b err=%b inst=%h pc=%h expected 1/1/0/80000000",
                t_valid_post_o, t_fetch_err_o, t_inst_o, t_pc_o);
        end
        ready_post_i = 1'b1; step(); ready_post_i = 1'b0;
    endtask

    task automatic test_data_wins();
        valid_pre_i = 1'b1; next_pc_i = 32'h8000_0010; arready_i = 1'b1; rvalid_i = 1'b0;
        step();
        valid_pre_i = 1'b0;
        step();
        arready_i = 1'b0;
        checks++;
        if (t_rready_o !== 1'b1) begin
            errors++; $display("FAIL dw_data: got rready=%b expected 1", t_rready_o);
        end
        step(); step();
        rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
        step();
        rvalid_i = 1'b0;
        checks++;
        if ({t_valid_post_o, t_fetch_err_o, t_inst_o} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++; $display("FAIL data_wins: got v=%b err=%b inst=%h expected 1/0/12345678",
                t_valid_post_o, t_fetch_err_o, t_inst_o);
        end
        ready_post_i = 1'b1; step(); ready_post_i = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        valid_pre_i = 1'b1; next_pc_i = 32'h8000_0014; arready_i = 1'b1; rvalid_i = 1'b0;
        step();
        valid_pre_i = 1'b0;
        step();
        checks++;
        if (t_rready_o !== 1'b1) begin
            errors++; $display("FAIL mid_data: got rready=%b expected 1", t_rready_o);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({t_ready_pre_o, t_arvalid_o, t_rready_o, t_valid_post_o, t_pc_o} !== {4'b0000, 32'h8000_0000}) begin
            errors++; $display("FAIL async_rst: got hs=%b pc=%h expected 0000/80000000",
                {t_ready_pre_o, t_arvalid_o, t_rready_o, t_valid_post_o}, t_pc_o);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({t_arvalid_o, t_araddr_o} !== {1'b1, 32'h8000_0000}) begin
            errors++; $display("FAIL reboot: got %b/%h expected 1/80000000", t_arvalid_o, t_araddr_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_ar_stall();
        test_bus_error();
        test_misaligned();
        test_timeout();
        test_data_wins();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
